// File: rtl/fft_pkg.sv
// Shared FFT front-end types: complex lane sample, lane vector and delay-buffer state.
package fft_pkg;

  localparam int unsigned FFT_DATA_W    = 9;
  localparam int unsigned FFT_UNIT_SIZE = 16;

  typedef struct packed {
    logic signed [FFT_DATA_W-1:0] re;
    logic signed [FFT_DATA_W-1:0] im;
  } cplx_s;

  typedef cplx_s [FFT_UNIT_SIZE-1:0] lane_vec_t;

  typedef enum logic {
    FILL = 1'b0,
    PAIR = 1'b1
  } buf_state_e;

endpackage

// File: rtl/sr_delay_buf_mem.sv
// DEPTH-entry lane-vector register file: synchronous write, asynchronous read.
module sr_delay_buf_mem
  import fft_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  lane_vec_t     i_wdata,
  input  logic [AW-1:0] i_raddr,
  output lane_vec_t     o_rdata_c
);

  lane_vec_t r_mem [DEPTH];

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/sr_delay_buf.sv
// Half-frame delay buffer pairing stored first-half beats with incoming second-half beats.
// Optional idle-timeout recovery enabled by defining SR_DELAY_BUF_TIMEOUT_EN.
module sr_delay_buf
  import fft_pkg::*;
#(
  parameter  int unsigned DATA_W    = FFT_DATA_W,
  parameter  int unsigned UNIT_SIZE = FFT_UNIT_SIZE,
  parameter  int unsigned DEPTH     = 16,
`ifdef SR_DELAY_BUF_TIMEOUT_EN
  parameter  int unsigned TIMEOUT   = 64,
`endif
  localparam int unsigned AW        = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             din_valid,
  input  logic [UNIT_SIZE-1:0][DATA_W-1:0] din_real,
  input  logic [UNIT_SIZE-1:0][DATA_W-1:0] din_imag,
`ifdef SR_DELAY_BUF_TIMEOUT_EN
  output logic                             timeout_err,
`endif
  output logic                             valid_out,
  output logic [UNIT_SIZE-1:0][DATA_W-1:0] sr_real,
  output logic [UNIT_SIZE-1:0][DATA_W-1:0] sr_imag,
  output logic [UNIT_SIZE-1:0][DATA_W-1:0] org_real,
  output logic [UNIT_SIZE-1:0][DATA_W-1:0] org_imag,
  output logic [AW-1:0]                    pair_idx,
  output logic                             frame_done
);

  localparam logic [AW-1:0] LAST_BEAT = AW'(DEPTH - 1);

  buf_state_e    r_state;
  buf_state_e    w_state_nxt;
  logic [AW-1:0] r_beat_cnt;
  logic [AW-1:0] w_cnt_nxt;
  logic          w_wr_en;
  logic          w_pair_beat;
  logic          w_timeout;
  lane_vec_t     w_wr_vec;
  lane_vec_t     w_rd_vec;

  logic                             r_valid_out;
  logic                             r_frame_done;
  logic [AW-1:0]                    r_pair_idx;
  logic [UNIT_SIZE-1:0][DATA_W-1:0] r_sr_real;
  logic [UNIT_SIZE-1:0][DATA_W-1:0] r_sr_imag;
  logic [UNIT_SIZE-1:0][DATA_W-1:0] r_org_real;
  logic [UNIT_SIZE-1:0][DATA_W-1:0] r_org_imag;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= FILL;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_cnt_nxt;
    end
  end

  // Next state: advance only on accepted beats, toggle FILL/PAIR at each half-frame end
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    if (din_valid) begin
      w_cnt_nxt = r_beat_cnt + AW'(1);
      if (r_beat_cnt == LAST_BEAT) begin
        w_cnt_nxt   = '0;
        w_state_nxt = (r_state == FILL) ? PAIR : FILL;
      end
    end
    if (w_timeout) begin
      w_state_nxt = FILL;
      w_cnt_nxt   = '0;
    end
  end

  // Output decode
  always_comb begin
    w_wr_en     = 1'b0;
    w_pair_beat = 1'b0;
    if (din_valid) begin
      w_wr_en     = (r_state == FILL);
      w_pair_beat = (r_state == PAIR);
    end
  end

  always_comb begin
    w_wr_vec = '0;
    for (int i = 0; i < UNIT_SIZE; i++) begin
      w_wr_vec[i].re = din_real[i];
      w_wr_vec[i].im = din_imag[i];
    end
  end

  sr_delay_buf_mem #(
    .DEPTH (DEPTH)
  ) u_mem (
    .clk       (clk),
    .i_we      (w_wr_en),
    .i_waddr   (r_beat_cnt),
    .i_wdata   (w_wr_vec),
    .i_raddr   (r_beat_cnt),
    .o_rdata_c (w_rd_vec)
  );

  // Pair output registers; data holds while no pair beat is presented
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid_out  <= 1'b0;
      r_frame_done <= 1'b0;
      r_pair_idx   <= '0;
      r_sr_real    <= '0;
      r_sr_imag    <= '0;
      r_org_real   <= '0;
      r_org_imag   <= '0;
    end else begin
      r_valid_out  <= w_pair_beat;
      r_frame_done <= w_pair_beat && (r_beat_cnt == LAST_BEAT);
      if (w_pair_beat) begin
        r_pair_idx <= r_beat_cnt;
        r_org_real <= din_real;
        r_org_imag <= din_imag;
        for (int i = 0; i < UNIT_SIZE; i++) begin
          r_sr_real[i] <= w_rd_vec[i].re;
          r_sr_imag[i] <= w_rd_vec[i].im;
        end
      end
    end
  end

  assign valid_out  = r_valid_out;
  assign frame_done = r_frame_done;
  assign pair_idx   = r_pair_idx;
  assign sr_real    = r_sr_real;
  assign sr_imag    = r_sr_imag;
  assign org_real   = r_org_real;
  assign org_imag   = r_org_imag;

`ifdef SR_DELAY_BUF_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT + 1);

  logic [IW-1:0] r_idle;
  logic          r_timeout_err;
  logic          w_partial;

  assign w_partial = (r_state != FILL) || (r_beat_cnt != '0);
  // Fires on the idle cycle that brings the counter to TIMEOUT
  assign w_timeout = !din_valid && w_partial && (r_idle == IW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_idle        <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (din_valid || w_timeout) r_idle <= '0;
      else if (w_partial)         r_idle <= r_idle + IW'(1);
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_timeout = 1'b0;
`endif

endmodule
